// File: rtl/ysyx_25040105_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, register-file write port,
// issue/decode scoreboard query signals and a debug view of the arbitration state.
interface ysyx_25040105_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // Handshake: a requester holds valid with stable waddr/wdata; the write is
    // taken on a rising edge where valid && ready; ready never rises without valid.
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_waddr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_waddr;
    logic [DATA_WIDTH-1:0] b_wdata;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  rs1_hazard;
    logic                  rs2_hazard;
    logic                  rs1_fwd_valid;
    logic [DATA_WIDTH-1:0] rs1_fwd_data;
    logic                  rs2_fwd_valid;
    logic [DATA_WIDTH-1:0] rs2_fwd_data;

    logic                  dbg_last_grant;

    modport master (
        output a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
        output issue_valid, issue_rd, rs1, rs2,
        input  a_ready, b_ready, rf_wen, rf_waddr, rf_wdata,
        input  rs1_hazard, rs2_hazard, rs1_fwd_valid, rs1_fwd_data,
        input  rs2_fwd_valid, rs2_fwd_data, dbg_last_grant
    );

    modport slave (
        input  a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
        input  issue_valid, issue_rd, rs1, rs2,
        output a_ready, b_ready, rf_wen, rf_waddr, rf_wdata,
        output rs1_hazard, rs2_hazard, rs1_fwd_valid, rs1_fwd_data,
        output rs2_fwd_valid, rs2_fwd_data, dbg_last_grant
    );
endinterface

// File: rtl/ysyx_25040105_wb_arbiter.sv
// Round-robin EXU/LSU writeback arbiter with register busy scoreboard.
// Define YSYX_25040105_WB_FWD_EN to forward the registered write data to decode.
module ysyx_25040105_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_25040105_wb_arbiter_if.slave  bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic            last_grant;
    logic            grant_a;
    logic            grant_b;
    logic            xfer;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // A wins a contention unless it was the most recent winner.
    always_comb begin
        grant_a = bus.a_valid && (!bus.b_valid || last_grant == GRANT_B);
        grant_b = bus.b_valid && !grant_a;
        bus.a_ready = grant_a && !rst;
        bus.b_ready = grant_b && !rst;
        xfer = bus.a_ready || bus.b_ready;
        bus.dbg_last_grant = last_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= GRANT_B;
            bus.rf_wen   <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else if (xfer) begin
            last_grant   <= bus.b_ready;
            bus.rf_wen   <= bus.b_ready ? (bus.b_waddr != '0) : (bus.a_waddr != '0);
            bus.rf_waddr <= bus.b_ready ? bus.b_waddr : bus.a_waddr;
            bus.rf_wdata <= bus.b_ready ? bus.b_wdata : bus.a_wdata;
        end else begin
            bus.rf_wen   <= 1'b0;
        end
    end

    // Set is applied after clear so a same-edge reissue keeps the bit pending.
    always_comb begin
        busy_nxt = busy;
        if (bus.rf_wen)
            busy_nxt[bus.rf_waddr] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0)
            busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

`ifdef YSYX_25040105_WB_FWD_EN
    logic fwd1;
    logic fwd2;
    always_comb begin
        fwd1 = bus.rf_wen && bus.rs1 != '0 && bus.rs1 == bus.rf_waddr;
        fwd2 = bus.rf_wen && bus.rs2 != '0 && bus.rs2 == bus.rf_waddr;
        bus.rs1_fwd_valid = fwd1;
        bus.rs2_fwd_valid = fwd2;
        bus.rs1_fwd_data  = fwd1 ? bus.rf_wdata : '0;
        bus.rs2_fwd_data  = fwd2 ? bus.rf_wdata : '0;
        bus.rs1_hazard    = busy[bus.rs1] && !fwd1;
        bus.rs2_hazard    = busy[bus.rs2] && !fwd2;
    end
`else
    always_comb begin
        bus.rs1_fwd_valid = 1'b0;
        bus.rs2_fwd_valid = 1'b0;
        bus.rs1_fwd_data  = '0;
        bus.rs2_fwd_data  = '0;
        bus.rs1_hazard    = busy[bus.rs1];
        bus.rs2_hazard    = busy[bus.rs2];
    end
`endif
endmodule

// File: tb/tb_ysyx_25040105_wb_arbiter.sv
// Directed bench for the writeback arbiter: grants, registered write, scoreboard, reset.
module tb_ysyx_25040105_wb_arbiter;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  ysyx_25040105_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  ysyx_25040105_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_waddr = '0; bus.a_wdata = '0;
    bus.b_valid = 1'b0; bus.b_waddr = '0; bus.b_wdata = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;

    // Reset state; ready held low during reset even with valid
    step();
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    settle();
    chk("rst_a_ready", {31'b0, bus.a_ready}, 32'd0);
    chk("rst_b_ready", {31'b0, bus.b_ready}, 32'd0);
    step();
    chk("rst_rf_wen", {31'b0, bus.rf_wen}, 32'd0);
    chk("rst_rf_waddr", {27'b0, bus.rf_waddr}, 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_last_grant", {31'b0, bus.dbg_last_grant}, 32'd1);
    rst = 1'b0;

    // Contention for 4 cycles: A,B,A,B with rf_waddr lagging by one cycle
    bus.a_waddr = 5'd1; bus.a_wdata = 32'h0000_00A1;
    bus.b_waddr = 5'd2; bus.b_wdata = 32'h0000_00B2;
    settle();
    chk("rr0_a_ready", {31'b0, bus.a_ready}, 32'd1);
    chk("rr0_b_ready", {31'b0, bus.b_ready}, 32'd0);
    step();
    chk("rr1_rf_wen", {31'b0, bus.rf_wen}, 32'd1);
    chk("rr1_rf_waddr", {27'b0, bus.rf_waddr}, 32'd1);
    chk("rr1_rf_wdata", bus.rf_wdata, 32'h0000_00A1);
    chk("rr1_a_ready", {31'b0, bus.a_ready}, 32'd0);
    chk("rr1_b_ready", {31'b0, bus.b_ready}, 32'd1);
    step();
    chk("rr2_rf_waddr", {27'b0, bus.rf_waddr}, 32'd2);
    chk("rr2_rf_wdata", bus.rf_wdata, 32'h0000_00B2);
    chk("rr2_a_ready", {31'b0, bus.a_ready}, 32'd1);
    step();
    chk("rr3_rf_waddr", {27'b0, bus.rf_waddr}, 32'd1);
    chk("rr3_b_ready", {31'b0, bus.b_ready}, 32'd1);
    step();
    chk("rr4_rf_waddr", {27'b0, bus.rf_waddr}, 32'd2);
    chk("rr4_rf_wen", {31'b0, bus.rf_wen}, 32'd1);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    settle();
    chk("idle_a_ready", {31'b0, bus.a_ready}, 32'd0);
    chk("idle_b_ready", {31'b0, bus.b_ready}, 32'd0);
    step();
    chk("idle_rf_wen", {31'b0, bus.rf_wen}, 32'd0);

    // Hazard on x5 through the A write of 0xDEADBEEF
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    step();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    bus.a_valid = 1'b1; bus.a_waddr = 5'd5; bus.a_wdata = 32'hDEAD_BEEF;
    settle();
    chk("x5_hazard_pending", {31'b0, bus.rs1_hazard}, 32'd1);
    chk("x6_no_hazard", {31'b0, bus.rs2_hazard}, 32'd0);
    chk("x5_a_ready", {31'b0, bus.a_ready}, 32'd1);
    step();
    bus.a_valid = 1'b0;
    settle();
    chk("x5_rf_wen", {31'b0, bus.rf_wen}, 32'd1);
    chk("x5_rf_waddr", {27'b0, bus.rf_waddr}, 32'd5);
`ifdef YSYX_25040105_WB_FWD_EN
    chk("x5_hazard_wen", {31'b0, bus.rs1_hazard}, 32'd0);
    chk("x5_fwd_valid", {31'b0, bus.rs1_fwd_valid}, 32'd1);
    chk("x5_fwd_data", bus.rs1_fwd_data, 32'hDEAD_BEEF);
`else
    chk("x5_hazard_wen", {31'b0, bus.rs1_hazard}, 32'd1);
    chk("x5_fwd_valid", {31'b0, bus.rs1_fwd_valid}, 32'd0);
    chk("x5_fwd_data", bus.rs1_fwd_data, 32'd0);
`endif
    chk("x6_fwd_valid", {31'b0, bus.rs2_fwd_valid}, 32'd0);
    step();
    chk("x5_hazard_cleared", {31'b0, bus.rs1_hazard}, 32'd0);
    chk("x5_rf_wen_off", {31'b0, bus.rf_wen}, 32'd0);

    // Reissue of x7 on the edge that clears it keeps x7 busy
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    step();
    bus.issue_valid = 1'b0;
    bus.b_valid = 1'b1; bus.b_waddr = 5'd7; bus.b_wdata = 32'h0000_0777;
    settle();
    chk("x7_b_ready", {31'b0, bus.b_ready}, 32'd1);
    step();
    bus.b_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    settle();
    chk("x7_rf_wen", {31'b0, bus.rf_wen}, 32'd1);
    step();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    settle();
    chk("x7_set_wins_rs1", {31'b0, bus.rs1_hazard}, 32'd1);
    chk("x7_set_wins_rs2", {31'b0, bus.rs2_hazard}, 32'd1);

    // B writes x0: accepted, but no register-file write
    bus.b_valid = 1'b1; bus.b_waddr = 5'd0; bus.b_wdata = 32'h0000_1234;
    bus.rs1 = 5'd0;
    settle();
    chk("x0_b_ready", {31'b0, bus.b_ready}, 32'd1);
    step();
    bus.b_valid = 1'b0;
    settle();
    chk("x0_rf_wen", {31'b0, bus.rf_wen}, 32'd0);
    chk("x0_rs1_hazard", {31'b0, bus.rs1_hazard}, 32'd0);

    // A transfer in N, reset in N+1: write dropped, busy cleared, A wins next
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    bus.a_valid = 1'b1; bus.a_waddr = 5'd9; bus.a_wdata = 32'h0000_0999;
    settle();
    chk("rst2_a_ready", {31'b0, bus.a_ready}, 32'd1);
    step();
    bus.issue_valid = 1'b0;
    rst = 1'b1;
    bus.b_valid = 1'b1; bus.b_waddr = 5'd4;
    settle();
    chk("rst2_pre_rf_wen", {31'b0, bus.rf_wen}, 32'd1);
    chk("rst2_last_grant_a", {31'b0, bus.dbg_last_grant}, 32'd0);
    chk("rst2_a_ready_low", {31'b0, bus.a_ready}, 32'd0);
    chk("rst2_b_ready_low", {31'b0, bus.b_ready}, 32'd0);
    step();
    rst = 1'b0;
    bus.rs1 = 5'd7; bus.rs2 = 5'd3;
    settle();
    chk("rst2_rf_wen", {31'b0, bus.rf_wen}, 32'd0);
    chk("rst2_rs1_hazard", {31'b0, bus.rs1_hazard}, 32'd0);
    chk("rst2_rs2_hazard", {31'b0, bus.rs2_hazard}, 32'd0);
    chk("rst2_a_wins", {31'b0, bus.a_ready}, 32'd1);
    chk("rst2_b_waits", {31'b0, bus.b_ready}, 32'd0);
    step();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    settle();
    chk("rst2_rf_waddr", {27'b0, bus.rf_waddr}, 32'd9);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
